// File: rtl/mtsp_trd_wakeup_if.sv
// -----------------------------------------------------------------------------
// mtsp_trd_wakeup_if
// Bundles the issue, response and status signals of the per-thread wait
// tracker so that the tracker and whoever drives it share one port list.
//
// Signals
//   ISSUE_nEN      issue strobe, active low
//   ISSUE_nTRD     issuing thread, one-cold (active low)
//   ISSUE_WAIT     request blocks its thread until the response returns
//   ISSUE_READY    request can be accepted this cycle (combinational)
//   RESP_EN        response valid, active high
//   RESP_TID       thread index of the response
//   PC_nAWAKE      one-cycle wake pulse per thread, active low
//   PENDING        bit t set while thread t has outstanding requests
//   ERR_UNDERFLOW  sticky response-without-request flag
//   ERR_TIMEOUT    sticky watchdog flag
//
// Modports
//   master  request/response source (scheduler side or testbench)
//   slave   the tracker itself
// -----------------------------------------------------------------------------
interface mtsp_trd_wakeup_if #(
   parameter int TRD_COUNT = 8
);
   localparam int TID_W = (TRD_COUNT > 1) ? $clog2(TRD_COUNT) : 1;

   logic                 ISSUE_nEN;
   logic [TRD_COUNT-1:0] ISSUE_nTRD;
   logic                 ISSUE_WAIT;
   logic                 ISSUE_READY;
   logic                 RESP_EN;
   logic [TID_W-1:0]     RESP_TID;
   logic [TRD_COUNT-1:0] PC_nAWAKE;
   logic [TRD_COUNT-1:0] PENDING;
   logic                 ERR_UNDERFLOW;
   logic                 ERR_TIMEOUT;

   modport master (
      output ISSUE_nEN, ISSUE_nTRD, ISSUE_WAIT, RESP_EN, RESP_TID,
      input  ISSUE_READY, PC_nAWAKE, PENDING, ERR_UNDERFLOW, ERR_TIMEOUT
   );

   modport slave (
      input  ISSUE_nEN, ISSUE_nTRD, ISSUE_WAIT, RESP_EN, RESP_TID,
      output ISSUE_READY, PC_nAWAKE, PENDING, ERR_UNDERFLOW, ERR_TIMEOUT
   );
endinterface

// File: rtl/mtsp_trd_wakeup.sv
// -----------------------------------------------------------------------------
// mtsp_trd_wakeup
// Per-thread memory-wait tracker feeding the thread scheduler's PC_nAWAKE.
// Counts each thread's outstanding wait-type requests, emits a one-cycle
// active-low wake pulse one cycle after the last response for a thread, and
// withholds ISSUE_READY while the selected thread's counter is saturated.
//
// Ports
//   CLK   main clock
//   RST   synchronous active-high reset
//   bus   mtsp_trd_wakeup_if.slave: issue/response inputs, ISSUE_READY,
//         PC_nAWAKE, PENDING, ERR_UNDERFLOW, ERR_TIMEOUT
//
// Build option
//   MTSP_WAKEUP_TIMEOUT_EN  adds a per-thread watchdog; a thread stuck in WAIT
//                           for TIMEOUT_CYCLES is force-woken and ERR_TIMEOUT
//                           latches. Without it ERR_TIMEOUT is tied low.
// -----------------------------------------------------------------------------
module mtsp_trd_wakeup #(
   parameter int TRD_COUNT      = 8,
   parameter int CNT_W          = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic              CLK,
   input logic              RST,
   mtsp_trd_wakeup_if.slave bus
);
   localparam int               TID_W   = (TRD_COUNT > 1) ? $clog2(TRD_COUNT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [TID_W:0]   TRD_LIM = (TID_W+1)'(TRD_COUNT);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WAKE} state_t;

   state_t               state     [TRD_COUNT];
   state_t               state_nxt [TRD_COUNT];
   logic [CNT_W-1:0]     cnt       [TRD_COUNT];
   logic [CNT_W-1:0]     cnt_nxt   [TRD_COUNT];
   logic [TRD_COUNT-1:0] inc;
   logic [TRD_COUNT-1:0] dec;
   logic [TRD_COUNT-1:0] expire;
   logic [TRD_COUNT-1:0] trd_hot;
   logic                 one_cold;
   logic [TID_W-1:0]     sel;
   logic                 tid_ok;
   logic                 issue_acc;
   logic                 underflow_set;
   logic                 err_underflow;
   logic                 err_timeout;

   // ---- issue select / acceptance (combinational) ----
   always_comb begin
      trd_hot  = ~bus.ISSUE_nTRD;
      // exactly one bit set: non-zero and clearing the lowest set bit leaves zero
      one_cold = (trd_hot != '0) && ((trd_hot & (trd_hot - TRD_COUNT'(1))) == '0);
      sel      = '0;
      for (int t = 0; t < TRD_COUNT; t++) begin
         if (trd_hot[t]) sel = TID_W'(t);
      end
   end

   assign bus.ISSUE_READY = one_cold && (cnt[sel] != CNT_MAX);
   assign issue_acc       = ~bus.ISSUE_nEN && bus.ISSUE_WAIT && bus.ISSUE_READY;
   assign tid_ok          = ({1'b0, bus.RESP_TID} < TRD_LIM);

   // A response may retire a same-cycle issue to a thread whose counter is 0.
   always_comb begin
      inc = '0;
      dec = '0;
      for (int t = 0; t < TRD_COUNT; t++) begin
         inc[t] = issue_acc && (sel == TID_W'(t));
         dec[t] = bus.RESP_EN && tid_ok && (bus.RESP_TID == TID_W'(t)) &&
                  ((cnt[t] != '0) || inc[t]);
      end
   end

   // Any valid response that retired nothing is an underflow.
   assign underflow_set = bus.RESP_EN && (dec == '0);

`ifdef MTSP_WAKEUP_TIMEOUT_EN
   localparam int             WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0]      wd [TRD_COUNT];
   logic [TRD_COUNT-1:0] resp_hit;

   always_comb begin
      resp_hit = '0;
      expire   = '0;
      for (int t = 0; t < TRD_COUNT; t++) begin
         resp_hit[t] = bus.RESP_EN && tid_ok && (bus.RESP_TID == TID_W'(t));
         expire[t]   = (state[t] == S_WAIT) && (wd[t] == WD_LIM) && !inc[t] && !resp_hit[t];
      end
   end

   // ---- watchdog registers ----
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int t = 0; t < TRD_COUNT; t++) wd[t] <= '0;
         err_timeout <= 1'b0;
      end else begin
         for (int t = 0; t < TRD_COUNT; t++) begin
            if ((state[t] != S_WAIT) || inc[t] || resp_hit[t]) wd[t] <= '0;
            else                                               wd[t] <= wd[t] + WD_W'(1);
         end
         if (expire != '0) err_timeout <= 1'b1;
      end
   end
`else
   assign expire      = '0;
   assign err_timeout = 1'b0;
`endif

   // ---- counter next value ----
   always_comb begin
      for (int t = 0; t < TRD_COUNT; t++) begin
         cnt_nxt[t] = cnt[t];
         if (expire[t])              cnt_nxt[t] = '0;
         else if (inc[t] && !dec[t]) cnt_nxt[t] = cnt[t] + CNT_W'(1);
         else if (dec[t] && !inc[t]) cnt_nxt[t] = cnt[t] - CNT_W'(1);
      end
   end

   // ---- FSM next state ----
   always_comb begin
      for (int t = 0; t < TRD_COUNT; t++) begin
         state_nxt[t] = state[t];
         case (state[t])
            S_IDLE:  if (cnt_nxt[t] != '0) state_nxt[t] = S_WAIT;
            S_WAIT:  if (cnt_nxt[t] == '0) state_nxt[t] = S_WAKE;
            S_WAKE:  state_nxt[t] = (cnt_nxt[t] != '0) ? S_WAIT : S_IDLE;
            default: state_nxt[t] = S_IDLE;
         endcase
      end
   end

   // ---- state / counter / error registers ----
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int t = 0; t < TRD_COUNT; t++) begin
            state[t] <= S_IDLE;
            cnt[t]   <= '0;
         end
         err_underflow <= 1'b0;
      end else begin
         for (int t = 0; t < TRD_COUNT; t++) begin
            state[t] <= state_nxt[t];
            cnt[t]   <= cnt_nxt[t];
         end
         if (underflow_set) err_underflow <= 1'b1;
      end
   end

   // ---- outputs, decoded from registers only ----
   always_comb begin
      bus.PC_nAWAKE = '1;
      bus.PENDING   = '0;
      for (int t = 0; t < TRD_COUNT; t++) begin
         bus.PC_nAWAKE[t] = (state[t] != S_WAKE);
         bus.PENDING[t]   = (cnt[t] != '0);
      end
   end

   assign bus.ERR_UNDERFLOW = err_underflow;
   assign bus.ERR_TIMEOUT   = err_timeout;

endmodule

// File: tb/tb_mtsp_trd_wakeup.sv
// -----------------------------------------------------------------------------
// tb_mtsp_trd_wakeup
// Directed bench for mtsp_trd_wakeup. Inputs are applied on the falling edge
// so the following rising edge samples them; registered outputs read on a
// falling edge reflect the rising edge just before it.
// -----------------------------------------------------------------------------
module tb_mtsp_trd_wakeup;
   localparam int TRD_COUNT = 8;
   localparam int CNT_W     = 4;
   localparam int TID_W     = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   mtsp_trd_wakeup_if #(.TRD_COUNT(TRD_COUNT)) bus ();

   mtsp_trd_wakeup #(
      .TRD_COUNT      (TRD_COUNT),
      .CNT_W          (CNT_W),
      .TIMEOUT_CYCLES (1024)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic drive_idle();
      bus.ISSUE_nEN  = 1'b1;
      bus.ISSUE_nTRD = '1;
      bus.ISSUE_WAIT = 1'b0;
      bus.RESP_EN    = 1'b0;
      bus.RESP_TID   = '0;
   endtask

   task automatic drive_issue(input int tid);
      logic [TRD_COUNT-1:0] hot;
      hot            = TRD_COUNT'(1) << tid;
      bus.ISSUE_nEN  = 1'b0;
      bus.ISSUE_nTRD = ~hot;
      bus.ISSUE_WAIT = 1'b1;
   endtask

   task automatic drive_resp(input int tid);
      bus.RESP_EN  = 1'b1;
      bus.RESP_TID = TID_W'(tid);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_idle();
      repeat (2) @(negedge clk);
      checks++; if (bus.PC_nAWAKE !== 8'hFF) begin errors++; $display("FAIL reset_nawake: got %h want ff", bus.PC_nAWAKE); end
      checks++; if (bus.PENDING !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h want 00", bus.PENDING); end
      checks++; if (bus.ERR_UNDERFLOW !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b want 0", bus.ERR_UNDERFLOW); end
      checks++; if (bus.ERR_TIMEOUT !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", bus.ERR_TIMEOUT); end
      bus.ISSUE_nTRD = 8'hFE;
      #1;
      checks++; if (bus.ISSUE_READY !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ISSUE_READY); end
      rst = 1'b0;
      drive_idle();
   endtask

   // issue thread 2 at cycle 0, response at cycle 5, pulse at cycle 6 only
   task automatic test_single_wake();
      @(negedge clk);
      drive_idle(); drive_issue(2);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         checks++; if (bus.PENDING !== 8'h04) begin errors++; $display("FAIL single_pending c%0d: got %h want 04", c, bus.PENDING); end
         checks++; if (bus.PC_nAWAKE !== 8'hFF) begin errors++; $display("FAIL single_nawake c%0d: got %h want ff", c, bus.PC_nAWAKE); end
         drive_idle();
         if (c == 5) drive_resp(2);
      end
      @(negedge clk);
      drive_idle();
      checks++; if (bus.PC_nAWAKE !== 8'hFB) begin errors++; $display("FAIL single_pulse: got %h want fb", bus.PC_nAWAKE); end
      checks++; if (bus.PENDING !== 8'h00) begin errors++; $display("FAIL single_pending_clr: got %h want 00", bus.PENDING); end
      @(negedge clk);
      checks++; if (bus.PC_nAWAKE !== 8'hFF) begin errors++; $display("FAIL single_pulse_end: got %h want ff", bus.PC_nAWAKE); end
   endtask

   // three issues to thread 0, then three responses: one pulse after the third
   task automatic test_multi_outstanding();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive_idle(); drive_issue(0);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (bus.PC_nAWAKE !== 8'hFF) begin errors++; $display("FAIL multi_nopulse r%0d: got %h want ff", i, bus.PC_nAWAKE); end
         checks++; if (bus.PENDING !== 8'h01) begin errors++; $display("FAIL multi_pending r%0d: got %h want 01", i, bus.PENDING); end
         drive_idle(); drive_resp(0);
      end
      @(negedge clk);
      drive_idle();
      checks++; if (bus.PC_nAWAKE !== 8'hFE) begin errors++; $display("FAIL multi_pulse: got %h want fe", bus.PC_nAWAKE); end
      checks++; if (bus.PENDING !== 8'h00) begin errors++; $display("FAIL multi_pending_clr: got %h want 00", bus.PENDING); end
      @(negedge clk);
      checks++; if (bus.PC_nAWAKE !== 8'hFF) begin errors++; $display("FAIL multi_pulse_end: got %h want ff", bus.PC_nAWAKE); end
   endtask

   // fill thread 7 to 15 outstanding, check back-pressure, then drain
   task automatic test_saturate();
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         drive_idle(); drive_issue(7);
         #1;
         if (i == 0 || i == 14) begin
            checks++; if (bus.ISSUE_READY !== 1'b1) begin errors++; $display("FAIL sat_ready_fill i%0d: got %b want 1", i, bus.ISSUE_READY); end
         end
      end
      // a blocked issue attempt to thread 7 must not be counted
      @(negedge clk);
      drive_idle(); drive_issue(7);
      #1;
      checks++; if (bus.ISSUE_READY !== 1'b0) begin errors++; $display("FAIL sat_ready_full: got %b want 0", bus.ISSUE_READY); end
      bus.ISSUE_nTRD = 8'hBF;
      bus.ISSUE_nEN  = 1'b1;
      #1;
      checks++; if (bus.ISSUE_READY !== 1'b1) begin errors++; $display("FAIL sat_ready_other: got %b want 1", bus.ISSUE_READY); end
      bus.ISSUE_nTRD = 8'h7F;
      bus.ISSUE_nEN  = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         drive_idle();
         bus.ISSUE_nTRD = 8'h7F;
         drive_resp(7);
         #1;
         checks++; if (bus.ISSUE_READY !== ((i == 0) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL sat_ready_drain i%0d: got %b want %b", i, bus.ISSUE_READY, (i != 0)); end
         checks++; if (bus.PC_nAWAKE !== 8'hFF) begin errors++; $display("FAIL sat_nopulse i%0d: got %h want ff", i, bus.PC_nAWAKE); end
      end
      @(negedge clk);
      drive_idle();
      checks++; if (bus.PC_nAWAKE !== 8'h7F) begin errors++; $display("FAIL sat_pulse: got %h want 7f", bus.PC_nAWAKE); end
      checks++; if (bus.PENDING !== 8'h00) begin errors++; $display("FAIL sat_pending_clr: got %h want 00", bus.PENDING); end
      @(negedge clk);
   endtask

   // cnt[3] = 1, same-cycle issue and response: no change, then one response wakes
   task automatic test_same_cycle();
      @(negedge clk);
      drive_idle(); drive_issue(3);
      @(negedge clk);
      drive_idle(); drive_issue(3); drive_resp(3);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         drive_idle();
         checks++; if (bus.PC_nAWAKE !== 8'hFF) begin errors++; $display("FAIL same_nopulse i%0d: got %h want ff", i, bus.PC_nAWAKE); end
         checks++; if (bus.PENDING !== 8'h08) begin errors++; $display("FAIL same_pending i%0d: got %h want 08", i, bus.PENDING); end
      end
      drive_resp(3);
      @(negedge clk);
      drive_idle();
      checks++; if (bus.PC_nAWAKE !== 8'hF7) begin errors++; $display("FAIL same_pulse: got %h want f7", bus.PC_nAWAKE); end
      checks++; if (bus.ERR_UNDERFLOW !== 1'b0) begin errors++; $display("FAIL same_underflow: got %b want 0", bus.ERR_UNDERFLOW); end
      @(negedge clk);
   endtask

   // re-issue in the WAKE cycle keeps the pulse; other threads stay untouched
   task automatic test_wake_reissue();
      @(negedge clk);
      drive_idle(); drive_issue(1);
      @(negedge clk);
      drive_idle(); drive_issue(5);
      @(negedge clk);
      drive_idle(); drive_resp(1);
      @(negedge clk);
      drive_idle(); drive_issue(1);
      checks++; if (bus.PC_nAWAKE !== 8'hFD) begin errors++; $display("FAIL reissue_pulse: got %h want fd", bus.PC_nAWAKE); end
      @(negedge clk);
      drive_idle(); drive_resp(1);
      checks++; if (bus.PC_nAWAKE !== 8'hFF) begin errors++; $display("FAIL reissue_pulse_end: got %h want ff", bus.PC_nAWAKE); end
      checks++; if (bus.PENDING !== 8'h22) begin errors++; $display("FAIL reissue_pending: got %h want 22", bus.PENDING); end
      @(negedge clk);
      drive_idle(); drive_resp(5);
      checks++; if (bus.PC_nAWAKE !== 8'hFD) begin errors++; $display("FAIL reissue_pulse2: got %h want fd", bus.PC_nAWAKE); end
      @(negedge clk);
      drive_idle();
      checks++; if (bus.PC_nAWAKE !== 8'hDF) begin errors++; $display("FAIL reissue_pulse5: got %h want df", bus.PC_nAWAKE); end
      checks++; if (bus.PENDING !== 8'h00) begin errors++; $display("FAIL reissue_pending_clr: got %h want 00", bus.PENDING); end
      @(negedge clk);
   endtask

   // response to idle thread 4 latches underflow; malformed selects are not ready
   task automatic test_underflow();
      @(negedge clk);
      drive_idle(); drive_resp(4);
      @(negedge clk);
      drive_idle();
      checks++; if (bus.ERR_UNDERFLOW !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b want 1", bus.ERR_UNDERFLOW); end
      checks++; if (bus.PC_nAWAKE !== 8'hFF) begin errors++; $display("FAIL underflow_nopulse: got %h want ff", bus.PC_nAWAKE); end
      @(negedge clk);
      checks++; if (bus.ERR_UNDERFLOW !== 1'b1) begin errors++; $display("FAIL underflow_sticky: got %b want 1", bus.ERR_UNDERFLOW); end
      bus.ISSUE_nTRD = 8'hF0;
      #1;
      checks++; if (bus.ISSUE_READY !== 1'b0) begin errors++; $display("FAIL ready_multicold: got %b want 0", bus.ISSUE_READY); end
      bus.ISSUE_nTRD = 8'hFF;
      #1;
      checks++; if (bus.ISSUE_READY !== 1'b0) begin errors++; $display("FAIL ready_none: got %b want 0", bus.ISSUE_READY); end
      drive_idle();
   endtask

   // five pending requests dropped by a one-cycle reset
   task automatic test_rst_mid();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive_idle(); drive_issue(i);
      end
      @(negedge clk);
      drive_idle();
      checks++; if (bus.PENDING !== 8'h1F) begin errors++; $display("FAIL rst_pre_pending: got %h want 1f", bus.PENDING); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.PENDING !== 8'h00) begin errors++; $display("FAIL rst_pending: got %h want 00", bus.PENDING); end
      checks++; if (bus.PC_nAWAKE !== 8'hFF) begin errors++; $display("FAIL rst_nawake: got %h want ff", bus.PC_nAWAKE); end
      checks++; if (bus.ERR_UNDERFLOW !== 1'b0) begin errors++; $display("FAIL rst_underflow_clr: got %b want 0", bus.ERR_UNDERFLOW); end
      drive_resp(0);
      @(negedge clk);
      drive_idle();
      checks++; if (bus.PC_nAWAKE !== 8'hFF) begin errors++; $display("FAIL rst_nopulse: got %h want ff", bus.PC_nAWAKE); end
      @(negedge clk);
      checks++; if (bus.ERR_UNDERFLOW !== 1'b1) begin errors++; $display("FAIL rst_late_underflow: got %b want 1", bus.ERR_UNDERFLOW); end
      checks++; if (bus.PC_nAWAKE !== 8'hFF) begin errors++; $display("FAIL rst_late_nopulse: got %h want ff", bus.PC_nAWAKE); end
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_single_wake();
      test_multi_outstanding();
      test_saturate();
      test_same_cycle();
      test_wake_reissue();
      test_underflow();
      test_rst_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL sim_timeout: got still running want finished");
      $fatal(1, "simulation time limit");
   end

endmodule
